// File: rtl/huffman_region_sequencer.sv
// -----------------------------------------------------------------------------
// huffman_region_sequencer
//
// Steers the big_values part of one MP3 granule/channel through a shared bank
// of Huffman pair decoders. Side info is latched on start. Pair n uses
// table_select[0] below region1_start, table_select[1] below region2_start,
// and table_select[2] after that. The block then feeds the serial bitstream
// into the selected decoder one bit per cycle. It counts the decoded (x,y)
// pairs and presents each one, with its pair index, in an output register
// that uses a valid/ready handshake.
//
// Table 0 regions produce (0,0) pairs without consuming any bits. A region
// that selects an illegal table (4 or 14) is reported as an error before any
// bits are consumed. The check applies only when the region holds at least
// one pair.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             1-cycle pulse: latch side info and begin a granule
//   big_values        number of pairs to decode
//   region1_start     first pair index of region 1
//   region2_start     first pair index of region 2
//   table_sel         {ts2, ts1, ts0}, 5 bits each
//   bit_valid/data    serial input bit; bit_ready marks consumption
//   dec_rst           reset pulse to the decoder bank (table switch or rst)
//   dec_table         decoder bank mux select
//   dec_axiiv/axiid   bit strobe and data forwarded to the decoder bank
//   dec_axiov         selected decoder has a complete pair (combinational)
//   dec_x, dec_y      signed pair from the selected decoder
//   pair_valid/ready  output pair handshake
//   pair_idx          pair index (covers lines 2*idx and 2*idx+1)
//   x_val, y_val      signed decoded values
//   busy, done, error status
// -----------------------------------------------------------------------------
module huffman_region_sequencer #(
  parameter int MAX_PAIRS = 288,
  parameter int IDX_W     = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDX_W-1:0]        big_values,
  input  logic [IDX_W-1:0]        region1_start,
  input  logic [IDX_W-1:0]        region2_start,
  input  logic [14:0]             table_sel,
  input  logic                    bit_valid,
  input  logic                    bit_data,
  output logic                    bit_ready,
  output logic                    dec_rst,
  output logic [4:0]              dec_table,
  output logic                    dec_axiiv,
  output logic                    dec_axiid,
  input  logic                    dec_axiov,
  input  logic signed [15:0]      dec_x,
  input  logic signed [15:0]      dec_y,
  output logic                    pair_valid,
  input  logic                    pair_ready,
  output logic [IDX_W-1:0]        pair_idx,
  output logic signed [15:0]      x_val,
  output logic signed [15:0]      y_val,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DECODE,
    S_ZERO,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [IDX_W-1:0] LP_MAX_PAIRS = IDX_W'(MAX_PAIRS);

  // Region index (0,1,2) of pair n. When r2 <= r1, any n >= r1 also satisfies
  // n >= r2, so region 1 is naturally empty.
  function automatic logic [1:0] region_of(input logic [IDX_W-1:0] n,
                                           input logic [IDX_W-1:0] r1,
                                           input logic [IDX_W-1:0] r2);
    if (n < r1)      return 2'd0;
    else if (n < r2) return 2'd1;
    else             return 2'd2;
  endfunction

  function automatic logic [4:0] table_of(input logic [1:0]  rgn,
                                          input logic [14:0] ts);
    case (rgn)
      2'd0:    return ts[4:0];
      2'd1:    return ts[9:5];
      default: return ts[14:10];
    endcase
  endfunction

  // Tables 4 and 14 do not exist in the MP3 Huffman set.
  function automatic logic is_bad_table(input logic [4:0] t);
    return (t == 5'd4) || (t == 5'd14);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [IDX_W-1:0]        r_bv;
  logic [IDX_W-1:0]        r_r1;
  logic [IDX_W-1:0]        r_r2;
  logic [14:0]             r_ts;
  logic [IDX_W-1:0]        r_count;
  logic [4:0]              r_dec_table;
  logic                    r_pair_valid;
  logic [IDX_W-1:0]        r_pair_idx;
  logic signed [15:0]      r_x;
  logic signed [15:0]      r_y;

  // ---------------------------------------------------------------------------
  // Start-time side-info checks, taken directly from the inputs. The side info
  // is latched on the same edge, so the registered copies are not yet valid.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_max_r;
  logic             w_rgn0_used;
  logic             w_rgn1_used;
  logic             w_rgn2_used;
  logic             w_start_err;
  logic [4:0]       w_first_tbl;
  logic             w_start_ok;

  assign w_max_r     = (region1_start > region2_start) ? region1_start : region2_start;
  assign w_rgn0_used = (big_values != '0) && (region1_start != '0);
  assign w_rgn1_used = (region2_start > region1_start) && (big_values > region1_start);
  assign w_rgn2_used = big_values > w_max_r;

  assign w_start_err = (big_values > LP_MAX_PAIRS)
                     || (w_rgn0_used && is_bad_table(table_sel[4:0]))
                     || (w_rgn1_used && is_bad_table(table_sel[9:5]))
                     || (w_rgn2_used && is_bad_table(table_sel[14:10]));

  assign w_first_tbl = table_of(region_of('0, region1_start, region2_start), table_sel);

  // start is ignored while busy, including while DONE still holds an undrained
  // final pair.
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_ERROR) ||
                                ((r_state == S_DONE) && !r_pair_valid));

  // ---------------------------------------------------------------------------
  // Per-pair sequencing terms
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_cnt_nxt;
  logic [1:0]       w_rgn_cur;
  logic [1:0]       w_rgn_nxt;
  logic [4:0]       w_tbl_nxt;
  logic             w_last;
  logic             w_out_free;
  logic             w_capture;

  assign w_cnt_nxt  = r_count + IDX_W'(1);
  assign w_rgn_cur  = region_of(r_count, r_r1, r_r2);
  assign w_rgn_nxt  = region_of(w_cnt_nxt, r_r1, r_r2);
  assign w_tbl_nxt  = table_of(w_rgn_nxt, r_ts);
  assign w_last     = (w_cnt_nxt == r_bv);

  // The output register can take a new pair when it is empty, or when its
  // current pair drains on this same edge.
  assign w_out_free = !r_pair_valid || pair_ready;

  assign w_capture  = w_out_free &&
                      ((r_state == S_ZERO) || ((r_state == S_DECODE) && dec_axiov));

  // ---------------------------------------------------------------------------
  // Decoder-bank interface
  // ---------------------------------------------------------------------------
  // No bit is taken in the cycle the decoder reports a pair. The decoder clears
  // itself on the next edge, so a bit never lands in the wrong table after a
  // region switch.
  assign bit_ready = (r_state == S_DECODE) && !dec_axiov && w_out_free;
  assign dec_axiiv = bit_valid && bit_ready;
  assign dec_axiid = bit_data;
  assign dec_table = r_dec_table;
  // The decoder bank is also reset during rst, so an aborted granule leaves no
  // partial code behind.
  assign dec_rst   = rst || (r_state == S_LOAD);

  // ---------------------------------------------------------------------------
  // Status and output pair
  // ---------------------------------------------------------------------------
  assign pair_valid = r_pair_valid;
  assign pair_idx   = r_pair_idx;
  assign x_val      = r_x;
  assign y_val      = r_y;
  assign busy       = (r_state == S_LOAD) || (r_state == S_DECODE) || (r_state == S_ZERO) ||
                      ((r_state == S_DONE) && r_pair_valid);
  assign done       = (r_state == S_DONE) && !r_pair_valid;
  assign error      = (r_state == S_ERROR);

  // ---------------------------------------------------------------------------
  // Sequencer FSM and output register
  // ---------------------------------------------------------------------------
  // NOTE: every register in this block is assigned with <=, so each branch
  // reads the values from before the edge. This is what allows the drain and
  // the new capture below to happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bv         <= '0;
      r_r1         <= '0;
      r_r2         <= '0;
      r_ts         <= '0;
      r_count      <= '0;
      r_dec_table  <= '0;
      r_pair_valid <= 1'b0;
      r_pair_idx   <= '0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      // Drain first. A capture later in this block overrides the clear.
      if (r_pair_valid && pair_ready) begin
        r_pair_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_start_ok) begin
            r_bv    <= big_values;
            r_r1    <= region1_start;
            r_r2    <= region2_start;
            r_ts    <= table_sel;
            r_count <= '0;
            if (w_start_err) begin
              r_state <= S_ERROR;
            end else if (big_values == '0) begin
              r_state <= S_DONE;
            end else begin
              r_dec_table <= w_first_tbl;
              r_state     <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          r_state <= (r_dec_table == 5'd0) ? S_ZERO : S_DECODE;
        end

        S_DECODE, S_ZERO: begin
          if (w_capture) begin
            r_pair_valid <= 1'b1;
            r_pair_idx   <= r_count;
            r_x          <= (r_state == S_DECODE) ? dec_x : 16'sd0;
            r_y          <= (r_state == S_DECODE) ? dec_y : 16'sd0;
            r_count      <= w_cnt_nxt;
            if (w_last) begin
              r_state <= S_DONE;
            end else if (w_rgn_nxt != w_rgn_cur) begin
              r_dec_table <= w_tbl_nxt;
              r_state     <= S_LOAD;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_region_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for huffman_region_sequencer.
//
// The decoder bank is stood in for by a token decoder. For every pair n that
// falls in a non-zero table, the bench picks a code length and a value (x,y).
// The stand-in decoder raises dec_axiov once it has taken that many bits, and
// clears itself on the following edge. The reference model walks the pairs
// with the region rules and builds the expected output queue, the decoder
// token queue, the total bit count, and the table sequence of the LOAD
// pulses. A granule is checked against a table of vectors. Hand sequences
// cover start-while-busy and reset in mid-granule.
// -----------------------------------------------------------------------------
module tb_huffman_region_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [8:0]         big_values;
  logic [8:0]         region1_start;
  logic [8:0]         region2_start;
  logic [14:0]        table_sel;
  logic               bit_valid;
  logic               bit_data;
  logic               bit_ready;
  logic               dec_rst;
  logic [4:0]         dec_table;
  logic               dec_axiiv;
  logic               dec_axiid;
  logic               dec_axiov;
  logic signed [15:0] dec_x;
  logic signed [15:0] dec_y;
  logic               pair_valid;
  logic               pair_ready;
  logic [8:0]         pair_idx;
  logic signed [15:0] x_val;
  logic signed [15:0] y_val;
  logic               busy;
  logic               done;
  logic               error;

  huffman_region_sequencer #(.MAX_PAIRS(288), .IDX_W(9)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .big_values    (big_values),
    .region1_start (region1_start),
    .region2_start (region2_start),
    .table_sel     (table_sel),
    .bit_valid     (bit_valid),
    .bit_data      (bit_data),
    .bit_ready     (bit_ready),
    .dec_rst       (dec_rst),
    .dec_table     (dec_table),
    .dec_axiiv     (dec_axiiv),
    .dec_axiid     (dec_axiid),
    .dec_axiov     (dec_axiov),
    .dec_x         (dec_x),
    .dec_y         (dec_y),
    .pair_valid    (pair_valid),
    .pair_ready    (pair_ready),
    .pair_idx      (pair_idx),
    .x_val         (x_val),
    .y_val         (y_val),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial forever #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct { int idx; int x; int y; } pair_t;
  typedef struct { int len; int x; int y; int tbl; } code_t;

  int     g_bv, g_r1, g_r2;
  int     g_ts [3];
  int     pair_x [512];
  int     pair_y [512];
  int     pair_len [512];
  pair_t  exp_q [$];
  code_t  dec_q [$];
  int     exp_tbls [$];
  int     exp_bits;

  function automatic int region_of(input int n);
    if (n < g_r1) return 0;
    if (n < g_r2) return 1;
    return 2;
  endfunction

  function automatic int table_of(input int n);
    return g_ts[region_of(n)];
  endfunction

  function automatic void build_model();
    bit err;
    err = 1'b0;
    exp_q.delete();
    dec_q.delete();
    exp_tbls.delete();
    exp_bits = 0;
    if (g_bv > 288) err = 1'b1;
    else
      for (int n = 0; n < g_bv; n++)
        if (table_of(n) == 4 || table_of(n) == 14) err = 1'b1;
    if (!err) begin
      for (int n = 0; n < g_bv; n++) begin
        if (n == 0 || region_of(n) != region_of(n - 1)) exp_tbls.push_back(table_of(n));
        if (table_of(n) == 0) begin
          exp_q.push_back('{n, 0, 0});
        end else begin
          exp_q.push_back('{n, pair_x[n], pair_y[n]});
          dec_q.push_back('{pair_len[n], pair_x[n], pair_y[n], table_of(n)});
          exp_bits += pair_len[n];
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stand-in decoder bank: pops one token per completed pair
  // ---------------------------------------------------------------------------
  int                 dm_cnt  = 0;
  logic               dm_have = 1'b0;
  logic signed [15:0] dm_x    = '0;
  logic signed [15:0] dm_y    = '0;
  int                 dm_tbl  = 0;

  assign dec_axiov = dm_have;
  assign dec_x     = dm_have ? dm_x : 16'sh7bad;
  assign dec_y     = dm_have ? dm_y : 16'sh7bad;

  always @(posedge clk) begin
    if (dec_rst) begin
      dm_cnt  <= 0;
      dm_have <= 1'b0;
    end else if (dm_have) begin
      dm_have <= 1'b0;
      dm_cnt  <= 0;
      if (dec_q.size() > 0) void'(dec_q.pop_front());
    end else if (dec_axiiv) begin
      dm_cnt <= dm_cnt + 1;
      if (dec_q.size() > 0 && dm_cnt + 1 >= dec_q[0].len) begin
        dm_have <= 1'b1;
        dm_x    <= 16'(dec_q[0].x);
        dm_y    <= 16'(dec_q[0].y);
        dm_tbl  <= dec_q[0].tbl;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus driver for the bit stream and pair_ready (posedge + 1)
  // ---------------------------------------------------------------------------
  int rdy_mode   = 0;   // 0 always ready, 1 random, 2 hold low 10 cycles on first pair
  int stall_left = 0;

  initial begin
    bit_valid  = 1'b0;
    bit_data   = 1'b0;
    pair_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_data  = 1'($urandom_range(0, 1));
      case (rdy_mode)
        1: pair_ready = 1'($urandom_range(0, 1));
        2: begin
          if (pair_valid && stall_left > 0) begin
            pair_ready = 1'b0;
            stall_left--;
          end else begin
            pair_ready = 1'b1;
          end
        end
        default: pair_ready = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor (negedge): scoreboard, stall/hold rules, stream accounting
  // ---------------------------------------------------------------------------
  int                 bits_seen  = 0;
  int                 pairs_seen = 0;
  int                 tbl_seen [$];
  bit                 ready_seen = 1'b0;
  bit                 prev_stall = 1'b0;
  logic [8:0]         prev_idx;
  logic signed [15:0] prev_x;
  logic signed [15:0] prev_y;

  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (dec_axiiv) bits_seen++;
        if (bit_ready) ready_seen = 1'b1;
        if (dec_rst)   tbl_seen.push_back(int'(dec_table));
        if (dec_axiov) check("dec_table_at_pair", int'(dec_table), dm_tbl);
        if (prev_stall) begin
          check("hold_valid", int'(pair_valid), 1);
          check("hold_idx", int'(pair_idx), int'(prev_idx));
          check("hold_x", int'(x_val), int'(prev_x));
          check("hold_y", int'(y_val), int'(prev_y));
        end
        if (pair_valid && !pair_ready) check("stall_bit_ready", int'(bit_ready), 0);
        prev_stall = pair_valid && !pair_ready;
        prev_idx   = pair_idx;
        prev_x     = x_val;
        prev_y     = y_val;
        if (pair_valid && pair_ready) begin
          pairs_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_pair_count", pairs_seen, pairs_seen - 1);
          end else begin
            e = exp_q.pop_front();
            check("pair_idx", int'(pair_idx), e.idx);
            check("pair_x", int'(x_val), e.x);
            check("pair_y", int'(y_val), e.y);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table and granule runner
  // ---------------------------------------------------------------------------
  typedef struct {
    int bv, r1, r2, ts0, ts1, ts2;
    int mode;
    bit directed;
    int exp_err, exp_pairs, exp_loads;
  } vec_t;

  vec_t vecs [11];

  task automatic pulse_start(input int bv, input int r1, input int r2,
                             input int ts0, input int ts1, input int ts2);
    @(posedge clk);
    #1;
    big_values    = 9'(bv);
    region1_start = 9'(r1);
    region2_start = 9'(r2);
    table_sel     = {5'(ts2), 5'(ts1), 5'(ts0)};
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic setup_granule(input vec_t v);
    g_bv = v.bv; g_r1 = v.r1; g_r2 = v.r2;
    g_ts[0] = v.ts0; g_ts[1] = v.ts1; g_ts[2] = v.ts2;
    if (!v.directed) begin
      for (int n = 0; n < 512; n++) begin
        pair_x[n]   = int'($urandom_range(0, 60)) - 30;
        pair_y[n]   = int'($urandom_range(0, 60)) - 30;
        pair_len[n] = int'($urandom_range(1, 6));
      end
    end
    build_model();
    bits_seen  = 0;
    pairs_seen = 0;
    ready_seen = 1'b0;
    tbl_seen.delete();
    rdy_mode   = v.mode;
    stall_left = 10;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    bit finished;
    int n_tbl;
    setup_granule(v);
    pulse_start(v.bv, v.r1, v.r2, v.ts0, v.ts1, v.ts2);
    finished = 1'b0;
    cyc      = 0;
    while (!finished && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && v.exp_err == 0 && v.bv > 0) check("busy_after_start", int'(busy), 1);
      if (done || error) finished = 1'b1;
    end
    check("granule_finished", int'(done || error), 1);
    if (v.bv == 0) check("zero_bv_latency", cyc, 1);
    check("error_flag", int'(error), v.exp_err);
    check("done_flag", int'(done), 1 - v.exp_err);
    check("busy_at_end", int'(busy), 0);
    check("pair_count", pairs_seen, v.exp_pairs);
    check("bits_consumed", bits_seen, exp_bits);
    check("load_count", tbl_seen.size(), v.exp_loads);
    n_tbl = (tbl_seen.size() < exp_tbls.size()) ? tbl_seen.size() : exp_tbls.size();
    for (int i = 0; i < n_tbl; i++) check("load_table", tbl_seen[i], exp_tbls[i]);
    check("leftover_pairs", exp_q.size(), 0);
    if (v.exp_err != 0) check("bit_ready_in_error", int'(ready_seen), 0);
    @(negedge clk);
    check("status_sticky", int'(done || error), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bit_ready"},  int'(bit_ready), 0);
    check({tag, "_dec_rst"},    int'(dec_rst), 0);
    check({tag, "_pair_valid"}, int'(pair_valid), 0);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_done"},       int'(done), 0);
    check({tag, "_error"},      int'(error), 0);
    check({tag, "_pair_idx"},   int'(pair_idx), 0);
    check({tag, "_x_val"},      int'(x_val), 0);
    check({tag, "_y_val"},      int'(y_val), 0);
    check({tag, "_dec_table"},  int'(dec_table), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    vec_t v;
    rst           = 1'b1;
    start         = 1'b0;
    big_values    = '0;
    region1_start = '0;
    region2_start = '0;
    table_sel     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("por");

    //          bv   r1   r2   ts0 ts1 ts2 mode dir err pairs loads
    vecs[0]  = '{3,   3,   3,   25, 4,  14, 2,   1,  0,  3,    1};
    vecs[1]  = '{4,   1,   3,   25, 0,  25, 1,   0,  0,  4,    3};
    vecs[2]  = '{0,   0,   0,   4,  4,  4,  0,   0,  0,  0,    0};
    vecs[3]  = '{5,   2,   0,   4,  1,  1,  0,   0,  1,  0,    0};
    vecs[4]  = '{289, 0,   0,   1,  1,  1,  0,   0,  1,  0,    0};
    vecs[5]  = '{288, 100, 200, 1,  15, 24, 1,   0,  0,  288,  3};
    vecs[6]  = '{10,  0,   0,   9,  4,  0,  1,   0,  0,  10,   1};
    vecs[7]  = '{6,   4,   2,   7,  4,  9,  1,   0,  0,  6,    2};
    vecs[8]  = '{6,   2,   5,   3,  14, 6,  0,   0,  1,  0,    0};
    vecs[9]  = '{3,   5,   8,   0,  4,  14, 0,   0,  0,  3,    1};
    vecs[10] = '{8,   3,   5,   2,  2,  2,  1,   0,  0,  8,    3};

    // Directed pair values for the first granule: (0,0), (1,-1), (20,0).
    pair_x[0] = 0;  pair_y[0] = 0;  pair_len[0] = 1;
    pair_x[1] = 1;  pair_y[1] = -1; pair_len[1] = 4;
    pair_x[2] = 20; pair_y[2] = 0;  pair_len[2] = 10;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Start while busy is ignored, then rst in mid-DECODE aborts the granule.
    v = '{20, 20, 20, 5, 1, 1, 0, 0, 0, 20, 1};
    setup_granule(v);
    pulse_start(v.bv, v.r1, v.r2, v.ts0, v.ts1, v.ts2);
    cyc = 0;
    while (pairs_seen < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_granule_reached", int'(pairs_seen >= 3), 1);
    pulse_start(0, 0, 0, 1, 1, 1);
    @(negedge clk);
    check("start_ignored_busy", int'(busy), 1);
    check("start_ignored_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("dec_rst_during_rst", int'(dec_rst), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("mid_rst");

    // A fresh granule after the abort decodes from pair 0.
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
